// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: a three-state fetch FSM issuing one cache request at a time
// into a small FIFO of {pc, instruction} entries, flushed by branch/jump redirects.
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic                     cpu_read_m1,
   output logic                     cpu_valid1,
   output logic [15:0]              cpu_address1,
   input  logic [15:0]              cpu_data1,
   input  logic                     cpu_inputReady1,
   input  logic                     redirect,
   input  logic [15:0]              redirect_pc,
   input  logic                     deq,
   output logic                     inst_valid,
   output logic [15:0]              inst_out,
   output logic [15:0]              inst_pc,
   output logic [1:0]               o_dbg_state,
   output logic [$clog2(DEPTH):0]   o_dbg_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Handshake: a request is valid while cpu_valid1=1 and cpu_address1 is held stable until
   // the cache answers with cpu_inputReady1=1 (data valid in that same cycle); only one request
   // is ever outstanding. deq pops the head entry when inst_valid=1 and is ignored otherwise.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_valid;
   logic [15:0]        r_fetch_pc;
   logic [15:0]        r_pending_pc;
   logic [CNT_W-1:0]   r_count;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [15:0]        r_mem_pc   [DEPTH];
   logic [15:0]        r_mem_data [DEPTH];

   logic               w_enq;
   logic               w_deq;
   logic [CNT_W-1:0]   w_count_after;

   // A redirect overrides both enqueue and dequeue in the same cycle.
   assign w_enq         = (r_state == S_REQ) && cpu_inputReady1 && !redirect;
   assign w_deq         = deq && (r_count != '0) && !redirect;
   assign w_count_after = r_count + CNT_W'(1) - CNT_W'(w_deq);

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_state      <= S_IDLE;
         r_valid      <= 1'b0;
         r_fetch_pc   <= RESET_PC;
         r_pending_pc <= RESET_PC;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (redirect) begin
                  r_fetch_pc <= redirect_pc;
               end else if (r_count < FULL_CNT) begin
                  r_state <= S_REQ;
                  r_valid <= 1'b1;
               end
            end
            S_REQ: begin
               if (redirect) begin
                  if (cpu_inputReady1) begin
                     r_fetch_pc <= redirect_pc;
                     r_state    <= S_IDLE;
                     r_valid    <= 1'b0;
                  end else begin
                     // The miss is still in flight; keep the address and wait it out in DROP.
                     r_pending_pc <= redirect_pc;
                     r_state      <= S_DROP;
                  end
               end else if (cpu_inputReady1) begin
                  r_fetch_pc <= r_fetch_pc + 16'd1;
                  if (w_count_after >= FULL_CNT) begin
                     r_state <= S_IDLE;
                     r_valid <= 1'b0;
                  end
               end
            end
            S_DROP: begin
               if (cpu_inputReady1) begin
                  r_fetch_pc <= redirect ? redirect_pc : r_pending_pc;
                  r_state    <= S_IDLE;
                  r_valid    <= 1'b0;
               end else if (redirect) begin
                  r_pending_pc <= redirect_pc;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_pc[i]   <= '0;
            r_mem_data[i] <= '0;
         end
      end else if (redirect) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_enq) begin
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
            r_mem_data[r_wr_ptr] <= cpu_data1;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (reset_n) !(w_enq && (r_count == FULL_CNT)))
      else $error("instr_fetch_queue: enqueue attempted while queue is full");

   assign cpu_valid1   = r_valid;
   assign cpu_read_m1  = r_valid;
   assign cpu_address1 = r_fetch_pc;
   assign inst_valid   = (r_count != '0);
   assign inst_out     = r_mem_data[r_rd_ptr];
   assign inst_pc      = r_mem_pc[r_rd_ptr];
   assign o_dbg_state  = r_state;
   assign o_dbg_count  = r_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a behavioural cache with programmable latency drives the DUT,
// and a queue-based reference model supplies every expected output.
module tb_instr_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          CW       = $clog2(DEPTH) + 1;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic          clk;
   logic          reset_n;
   logic          cpu_read_m1;
   logic          cpu_valid1;
   logic [15:0]   cpu_address1;
   logic [15:0]   cpu_data1;
   logic          cpu_inputReady1;
   logic          redirect;
   logic [15:0]   redirect_pc;
   logic          deq;
   logic          inst_valid;
   logic [15:0]   inst_out;
   logic [15:0]   inst_pc;
   logic [1:0]    o_dbg_state;
   logic [CW-1:0] o_dbg_count;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset_n(reset_n), .cpu_read_m1(cpu_read_m1), .cpu_valid1(cpu_valid1),
      .cpu_address1(cpu_address1), .cpu_data1(cpu_data1), .cpu_inputReady1(cpu_inputReady1),
      .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq), .inst_valid(inst_valid),
      .inst_out(inst_out), .inst_pc(inst_pc), .o_dbg_state(o_dbg_state), .o_dbg_count(o_dbg_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Expected queue contents, each entry {pc, instruction}.
   logic [31:0] exp_q[$];
   bit          m_busy;
   bit          m_drop;
   logic [15:0] m_pc;
   logic [15:0] m_pend;
   int          wait_cnt;
   int          cur_lat;
   int          lat_min = 0;
   int          lat_max = 0;

   function automatic logic [15:0] word_at(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_busy   = 1'b0;
      m_drop   = 1'b0;
      m_pc     = RESET_PC;
      m_pend   = RESET_PC;
      wait_cnt = 0;
      cur_lat  = lat_min;
   endtask

   task automatic model_step(input bit redir, input logic [15:0] rpc, input bit dq, input bit rdy);
      int n;
      n = exp_q.size();
      if (redir) exp_q.delete();
      else if (dq && n > 0) void'(exp_q.pop_front());
      if (!m_busy) begin
         if (redir) m_pc = rpc;
         else if (n < DEPTH) m_busy = 1'b1;
      end else if (!m_drop) begin
         if (redir) begin
            if (rdy) begin m_pc = rpc; m_busy = 1'b0; end
            else begin m_pend = rpc; m_drop = 1'b1; end
         end else if (rdy) begin
            exp_q.push_back({m_pc, word_at(m_pc)});
            m_pc = m_pc + 16'd1;
            if (exp_q.size() >= DEPTH) m_busy = 1'b0;
         end
      end else if (rdy) begin
         m_pc   = redir ? rpc : m_pend;
         m_busy = 1'b0;
         m_drop = 1'b0;
      end else if (redir) begin
         m_pend = rpc;
      end
   endtask

   // Called at a falling edge; plays the cache for one cycle and advances the model.
   task automatic drive_cycle(input bit redir, input logic [15:0] rpc, input bit dq);
      bit rdy;
      bit was_valid;
      was_valid       = cpu_valid1;
      rdy             = was_valid && (wait_cnt >= cur_lat);
      redirect        = redir;
      redirect_pc     = rpc;
      deq             = dq;
      cpu_inputReady1 = rdy;
      cpu_data1       = rdy ? word_at(cpu_address1) : 16'($urandom);
      @(posedge clk);
      model_step(redir, rpc, dq, rdy);
      if (was_valid) begin
         if (rdy) begin wait_cnt = 0; cur_lat = $urandom_range(lat_max, lat_min); end
         else wait_cnt++;
      end
      @(negedge clk);
      redirect        = 1'b0;
      deq             = 1'b0;
      cpu_inputReady1 = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      reset_n = 1'b0;
   endtask

   task automatic test_reset();
      lat_min = 0; lat_max = 0;
      do_reset();
      repeat (3) drive_cycle(1'b0, 16'h0, 1'b0);
      cur_lat = 8;
      repeat (2) drive_cycle(1'b0, 16'h0, 1'b0);
      #2 reset_n = 1'b1;
      #1;
      checks++; if (cpu_valid1 !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", cpu_valid1); end
      checks++; if (cpu_read_m1 !== 1'b0) begin failures++; $display("FAIL reset_read: got %b want 0", cpu_read_m1); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
      checks++; if (cpu_address1 !== RESET_PC) begin failures++; $display("FAIL reset_addr: got %h want %h", cpu_address1, RESET_PC); end
      checks++; if (inst_out !== 16'h0) begin failures++; $display("FAIL reset_inst_out: got %h want 0000", inst_out); end
      checks++; if (inst_pc !== 16'h0) begin failures++; $display("FAIL reset_inst_pc: got %h want 0000", inst_pc); end
      checks++; if (o_dbg_count !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", o_dbg_count); end
   endtask

   task automatic test_startup();
      lat_min = 0; lat_max = 0;
      do_reset();
      checks++; if (cpu_valid1 !== 1'b0) begin failures++; $display("FAIL startup_idle: valid %b want 0", cpu_valid1); end
      drive_cycle(1'b0, 16'h0, 1'b0);
      checks++; if (cpu_valid1 !== 1'b1) begin failures++; $display("FAIL startup_req: valid %b want 1", cpu_valid1); end
      checks++; if (cpu_address1 !== RESET_PC) begin failures++; $display("FAIL startup_addr0: got %h want %h", cpu_address1, RESET_PC); end
      for (int i = 1; i < 4; i++) begin
         drive_cycle(1'b0, 16'h0, 1'b0);
         checks++;
         if (cpu_address1 !== RESET_PC + 16'(i)) begin
            failures++; $display("FAIL startup_addr%0d: got %h want %h", i, cpu_address1, RESET_PC + 16'(i));
         end
      end
      drive_cycle(1'b0, 16'h0, 1'b0);
      checks++; if (cpu_valid1 !== 1'b0) begin failures++; $display("FAIL startup_full_valid: got %b want 0", cpu_valid1); end
      checks++; if (o_dbg_count !== CW'(4)) begin failures++; $display("FAIL startup_count: got %0d want 4", o_dbg_count); end
      checks++; if (inst_pc !== RESET_PC) begin failures++; $display("FAIL startup_head_pc: got %h want %h", inst_pc, RESET_PC); end
      checks++; if (inst_out !== word_at(RESET_PC)) begin failures++; $display("FAIL startup_head_data: got %h want %h", inst_out, word_at(RESET_PC)); end
      drive_cycle(1'b0, 16'h0, 1'b0);
      checks++; if (cpu_valid1 !== 1'b0) begin failures++; $display("FAIL startup_stay_idle: got %b want 0", cpu_valid1); end
   endtask

   task automatic test_miss();
      drive_cycle(1'b1, 16'h0010, 1'b0);
      checks++; if (o_dbg_count !== '0) begin failures++; $display("FAIL miss_flush: count %0d want 0", o_dbg_count); end
      checks++; if (cpu_address1 !== 16'h0010) begin failures++; $display("FAIL miss_idle_redirect: addr %h want 0010", cpu_address1); end
      cur_lat = 6;
      drive_cycle(1'b0, 16'h0, 1'b0);
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (cpu_valid1 !== 1'b1 || cpu_address1 !== 16'h0010 || o_dbg_count !== '0) begin
            failures++; $display("FAIL miss_hold%0d: valid %b addr %h count %0d want 1/0010/0", k, cpu_valid1, cpu_address1, o_dbg_count);
         end
         drive_cycle(1'b0, 16'h0, 1'b0);
      end
      checks++; if (o_dbg_count !== CW'(1)) begin failures++; $display("FAIL miss_enq_count: got %0d want 1", o_dbg_count); end
      checks++; if (inst_pc !== 16'h0010) begin failures++; $display("FAIL miss_enq_pc: got %h want 0010", inst_pc); end
      checks++; if (inst_out !== word_at(16'h0010)) begin failures++; $display("FAIL miss_enq_data: got %h want %h", inst_out, word_at(16'h0010)); end
      checks++; if (cpu_address1 !== 16'h0011) begin failures++; $display("FAIL miss_next_addr: got %h want 0011", cpu_address1); end
   endtask

   task automatic test_redirect_drop();
      bit left_drop;
      lat_min = 0; lat_max = 0;
      do_reset();
      drive_cycle(1'b1, 16'h0006, 1'b0);
      repeat (3) drive_cycle(1'b0, 16'h0, 1'b0);
      cur_lat = 10;
      drive_cycle(1'b0, 16'h0, 1'b0);
      checks++; if (o_dbg_count !== CW'(2) || cpu_address1 !== 16'h0008) begin
         failures++; $display("FAIL drop_setup: count %0d addr %h want 2/0008", o_dbg_count, cpu_address1);
      end
      drive_cycle(1'b1, 16'h0040, 1'b0);
      checks++; if (inst_valid !== 1'b0 || o_dbg_count !== '0) begin
         failures++; $display("FAIL drop_flush: inst_valid %b count %0d want 0/0", inst_valid, o_dbg_count);
      end
      checks++; if (cpu_valid1 !== 1'b1) begin failures++; $display("FAIL drop_valid: got %b want 1", cpu_valid1); end
      left_drop = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (cpu_valid1 === 1'b0) begin left_drop = 1'b1; break; end
         checks++; if (cpu_address1 !== 16'h0008) begin failures++; $display("FAIL drop_hold%0d: addr %h want 0008", k, cpu_address1); end
         drive_cycle(1'b0, 16'h0, 1'b1);
      end
      checks++; if (!left_drop) begin failures++; $display("FAIL drop_timeout: still requesting after 20 cycles, want idle"); end
      checks++; if (cpu_address1 !== 16'h0040) begin failures++; $display("FAIL drop_new_pc: got %h want 0040", cpu_address1); end
      checks++; if (o_dbg_count !== '0) begin failures++; $display("FAIL drop_discard: count %0d want 0", o_dbg_count); end
      drive_cycle(1'b0, 16'h0, 1'b0);
      checks++; if (cpu_valid1 !== 1'b1 || cpu_address1 !== 16'h0040) begin
         failures++; $display("FAIL drop_resume: valid %b addr %h want 1/0040", cpu_valid1, cpu_address1);
      end
      drive_cycle(1'b0, 16'h0, 1'b0);
      checks++; if (inst_pc !== 16'h0040 || inst_out !== word_at(16'h0040)) begin
         failures++; $display("FAIL drop_first_entry: pc %h data %h want 0040/%h", inst_pc, inst_out, word_at(16'h0040));
      end
   endtask

   task automatic test_full_stream();
      logic [15:0] next_pc;
      lat_min = 0; lat_max = 0;
      do_reset();
      repeat (5) drive_cycle(1'b0, 16'h0, 1'b0);
      next_pc = RESET_PC;
      for (int i = 0; i < 24; i++) begin
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== next_pc) begin
            failures++; $display("FAIL stream_pop%0d: valid %b pc %h want 1/%h", i, inst_valid, inst_pc, next_pc);
         end
         checks++; if (o_dbg_count > CW'(DEPTH)) begin failures++; $display("FAIL stream_count%0d: got %0d want <=4", i, o_dbg_count); end
         if (i >= 4) begin
            checks++; if (cpu_valid1 !== 1'b1) begin failures++; $display("FAIL stream_sustain%0d: valid %b want 1", i, cpu_valid1); end
         end
         drive_cycle(1'b0, 16'h0, 1'b1);
         next_pc = next_pc + 16'd1;
      end
   endtask

   task automatic test_wrap();
      drive_cycle(1'b1, 16'hFFFF, 1'b0);
      checks++; if (cpu_address1 !== 16'hFFFF || inst_valid !== 1'b0) begin
         failures++; $display("FAIL wrap_redirect: addr %h inst_valid %b want ffff/0", cpu_address1, inst_valid);
      end
      repeat (3) drive_cycle(1'b0, 16'h0, 1'b0);
      checks++; if (inst_pc !== 16'hFFFF || inst_out !== word_at(16'hFFFF)) begin
         failures++; $display("FAIL wrap_first: pc %h data %h want ffff/%h", inst_pc, inst_out, word_at(16'hFFFF));
      end
      drive_cycle(1'b0, 16'h0, 1'b1);
      checks++; if (inst_pc !== 16'h0000 || inst_out !== word_at(16'h0000)) begin
         failures++; $display("FAIL wrap_second: pc %h data %h want 0000/%h", inst_pc, inst_out, word_at(16'h0000));
      end
   endtask

   task automatic test_redirect_deq();
      lat_min = 0; lat_max = 0;
      do_reset();
      repeat (4) drive_cycle(1'b0, 16'h0, 1'b0);
      checks++; if (o_dbg_count !== CW'(3)) begin failures++; $display("FAIL rdeq_setup: count %0d want 3", o_dbg_count); end
      drive_cycle(1'b1, 16'h0080, 1'b1);
      checks++; if (o_dbg_count !== '0 || inst_valid !== 1'b0) begin
         failures++; $display("FAIL rdeq_flush: count %0d inst_valid %b want 0/0", o_dbg_count, inst_valid);
      end
      checks++; if (cpu_valid1 !== 1'b0 || cpu_address1 !== 16'h0080) begin
         failures++; $display("FAIL rdeq_idle: valid %b addr %h want 0/0080", cpu_valid1, cpu_address1);
      end
      drive_cycle(1'b0, 16'h0, 1'b0);
      checks++; if (cpu_valid1 !== 1'b1 || cpu_address1 !== 16'h0080) begin
         failures++; $display("FAIL rdeq_resume: valid %b addr %h want 1/0080", cpu_valid1, cpu_address1);
      end
   endtask

   task automatic test_random();
      bit          r_redir;
      logic [15:0] r_pc;
      lat_min = 0; lat_max = 4;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         checks++; if (inst_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL rand_inst_valid@%0d: got %b want %b", i, inst_valid, exp_q.size() != 0); end
         checks++; if (o_dbg_count !== CW'(exp_q.size())) begin failures++; $display("FAIL rand_count@%0d: got %0d want %0d", i, o_dbg_count, exp_q.size()); end
         checks++; if (cpu_valid1 !== m_busy || cpu_read_m1 !== m_busy) begin
            failures++; $display("FAIL rand_req@%0d: valid %b read %b want %b", i, cpu_valid1, cpu_read_m1, m_busy);
         end
         checks++; if (cpu_address1 !== m_pc) begin failures++; $display("FAIL rand_addr@%0d: got %h want %h", i, cpu_address1, m_pc); end
         if (exp_q.size() != 0) begin
            checks++; if ({inst_pc, inst_out} !== exp_q[0]) begin
               failures++; $display("FAIL rand_head@%0d: got %h/%h want %h/%h", i, inst_pc, inst_out, exp_q[0][31:16], exp_q[0][15:0]);
            end
         end
         r_redir = ($urandom_range(9, 0) == 0);
         r_pc    = ($urandom_range(3, 0) == 0) ? 16'hFFFC + 16'($urandom_range(3, 0)) : 16'($urandom);
         drive_cycle(r_redir, r_pc, 1'($urandom_range(1, 0)));
      end
   endtask

   initial begin
      reset_n         = 1'b1;
      cpu_data1       = 16'h0;
      cpu_inputReady1 = 1'b0;
      redirect        = 1'b0;
      redirect_pc     = 16'h0;
      deq             = 1'b0;
      model_reset();
      test_reset();
      test_startup();
      test_miss();
      test_redirect_drop();
      test_full_stream();
      test_wrap();
      test_redirect_deq();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want normal completion");
      $fatal(1, "watchdog");
   end

endmodule
